// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage operand forwarding selects and load-use stall
// detection for the 5-stage RV32I core. Tracks EX/MEM/WB destination
// records internally so the core only presents decode-stage fields.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              mr;
    } ex_rec_t;

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              rw;
    } dst_rec_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    ex_rec_t          ex_q,  ex_d;
    dst_rec_t         mem_q, mem_d;
    dst_rec_t         wb_q,  wb_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic [1:0][REG_AW-1:0] ex_src;
    logic [1:0][1:0]        sel;

    // Load-use hazard: the load in EX produces rd too late for the ID consumer.
    // rs2 is compared even for I-type, which only costs a spurious stall.
    always_comb begin
        stall = id_valid & ex_q.vld & ex_q.mr & (ex_q.rd != '0) &
                ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
    end

    assign ex_src[0] = ex_q.rs1;
    assign ex_src[1] = ex_q.rs2;

    // Per-operand select: youngest producer (MEM) wins over WB; x0 never forwarded.
    for (genvar g = 0; g < 2; g++) begin : g_sel
        always_comb begin
            sel[g] = SEL_RF;
            if (ex_q.vld) begin
                if (mem_q.vld & mem_q.rw & (mem_q.rd != '0) & (mem_q.rd == ex_src[g]))
                    sel[g] = SEL_MEM;
                else if (wb_q.vld & wb_q.rw & (wb_q.rd != '0) & (wb_q.rd == ex_src[g]))
                    sel[g] = SEL_WB;
            end
        end
    end

    assign fwd_a_sel   = sel[0];
    assign fwd_b_sel   = sel[1];
    assign stall_count = stall_count_q;

    // Next pipeline records: flush or stall inject a single bubble into EX only.
    always_comb begin
        ex_d = '0;
        if (!(flush | stall)) begin
            ex_d.vld = id_valid;
            ex_d.rs1 = id_rs1;
            ex_d.rs2 = id_rs2;
            ex_d.rd  = id_rd;
            ex_d.rw  = id_reg_write;
            ex_d.mr  = id_mem_read;
        end
        mem_d.vld = ex_q.vld;
        mem_d.rd  = ex_q.rd;
        mem_d.rw  = ex_q.rw;
        wb_d      = mem_q;
    end

    // Saturating stall-cycle counter.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1))
            stall_count_d = stall_count_q + CNT_W'(1);
    end

    // Stage records and counter; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       rw, mr, fl;
    } stim_t;

    typedef struct {
        logic [1:0] a, b;
        logic       st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
    logic [1:0]  fwd_a_sel, fwd_b_sel, s_a, s_b;
    logic        stall, s_stall;
    logic [15:0] stall_count;
    logic [5:0]  s_count;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_cnt = '0;
    logic [5:0]  exp_sat = '0;
    stim_t       sq[$];
    exp_t        sbq[$];

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_count(stall_count)
    );

    // Narrow-counter instance used to reach saturation within a short run.
    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(6)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a_sel(s_a), .fwd_b_sel(s_b), .stall(s_stall), .stall_count(s_count)
    );

    function automatic stim_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                 logic rw, logic mr, logic fl);
        stim_t s;
        s.v = v; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.rw = rw; s.mr = mr; s.fl = fl;
        return s;
    endfunction

    function automatic exp_t ex(logic [1:0] a, logic [1:0] b, logic st);
        exp_t e;
        e.a = a; e.b = b; e.st = st;
        return e;
    endfunction

    task automatic drive(stim_t s);
        id_valid = s.v; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
        id_reg_write = s.rw; id_mem_read = s.mr; flush = s.fl;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            sq.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            sbq.push_back(ex(2'b00, 2'b00, 0));
        end
    endtask

    task automatic bump(logic st);
        if (st && exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
        if (st && exp_sat != 6'h3f) exp_sat = exp_sat + 6'd1;
    endtask

    task automatic test_reset;
        drive(mk(1, 9, 9, 9, 1, 1, 0));
        #3;
        checks++;
        if ({fwd_a_sel, fwd_b_sel, stall} !== 5'b0 || stall_count !== 16'd0 || s_count !== 6'd0) begin
            errors++;
            $display("FAIL reset: a=%b b=%b st=%b cnt=%0d scnt=%0d want all 0",
                     fwd_a_sel, fwd_b_sel, stall, stall_count, s_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fwd_mem;
        exp_t e;
        int   c = 0;
        sq.push_back(mk(1, 1, 2, 5, 1, 0, 0)); sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(1, 5, 5, 6, 1, 0, 0)); sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(0, 0, 0, 0, 0, 0, 0)); sbq.push_back(ex(2'b10, 2'b10, 0));
        idle(3);
        while (sq.size() > 0) begin
            @(negedge clk); drive(sq.pop_front()); #1;
            e = sbq.pop_front();
            checks++;
            if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st}) begin
                errors++;
                $display("FAIL fwd_mem c%0d: a=%b b=%b st=%b want a=%b b=%b st=%b",
                         c, fwd_a_sel, fwd_b_sel, stall, e.a, e.b, e.st);
            end
            checks++;
            if (stall_count !== exp_cnt) begin
                errors++;
                $display("FAIL fwd_mem_cnt c%0d: got %0d want %0d", c, stall_count, exp_cnt);
            end
            bump(e.st); c++;
        end
    endtask

    task automatic test_fwd_wb;
        exp_t e;
        int   c = 0;
        sq.push_back(mk(1, 1, 2, 7, 1, 0, 0));   sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(1, 3, 4, 8, 1, 0, 0));   sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(1, 10, 7, 11, 1, 0, 0)); sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(0, 0, 0, 0, 0, 0, 0));   sbq.push_back(ex(2'b00, 2'b01, 0));
        idle(2);
        while (sq.size() > 0) begin
            @(negedge clk); drive(sq.pop_front()); #1;
            e = sbq.pop_front();
            checks++;
            if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st}) begin
                errors++;
                $display("FAIL fwd_wb c%0d: a=%b b=%b st=%b want a=%b b=%b st=%b",
                         c, fwd_a_sel, fwd_b_sel, stall, e.a, e.b, e.st);
            end
            bump(e.st); c++;
        end
    endtask

    task automatic test_mem_priority;
        exp_t e;
        int   c = 0;
        sq.push_back(mk(1, 1, 2, 3, 1, 0, 0));  sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(1, 1, 2, 3, 1, 0, 0));  sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(1, 3, 4, 12, 1, 0, 0)); sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(0, 0, 0, 0, 0, 0, 0));  sbq.push_back(ex(2'b10, 2'b00, 0));
        idle(2);
        while (sq.size() > 0) begin
            @(negedge clk); drive(sq.pop_front()); #1;
            e = sbq.pop_front();
            checks++;
            if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st}) begin
                errors++;
                $display("FAIL mem_prio c%0d: a=%b b=%b st=%b want a=%b b=%b st=%b",
                         c, fwd_a_sel, fwd_b_sel, stall, e.a, e.b, e.st);
            end
            bump(e.st); c++;
        end
    endtask

    task automatic test_load_use;
        exp_t e;
        int   c = 0;
        sq.push_back(mk(1, 1, 2, 9, 1, 1, 0));  sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(1, 9, 4, 13, 1, 0, 0)); sbq.push_back(ex(2'b00, 2'b00, 1));
        sq.push_back(mk(1, 9, 4, 13, 1, 0, 0)); sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(0, 0, 0, 0, 0, 0, 0));  sbq.push_back(ex(2'b01, 2'b00, 0));
        idle(2);
        while (sq.size() > 0) begin
            @(negedge clk); drive(sq.pop_front()); #1;
            e = sbq.pop_front();
            checks++;
            if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st}) begin
                errors++;
                $display("FAIL load_use c%0d: a=%b b=%b st=%b want a=%b b=%b st=%b",
                         c, fwd_a_sel, fwd_b_sel, stall, e.a, e.b, e.st);
            end
            checks++;
            if (stall_count !== exp_cnt) begin
                errors++;
                $display("FAIL load_use_cnt c%0d: got %0d want %0d", c, stall_count, exp_cnt);
            end
            bump(e.st); c++;
        end
    endtask

    task automatic test_x0;
        exp_t e;
        int   c = 0;
        sq.push_back(mk(1, 1, 2, 0, 1, 0, 0));  sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(1, 0, 0, 14, 1, 0, 0)); sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(1, 5, 6, 0, 1, 1, 0));  sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(1, 0, 0, 15, 1, 0, 0)); sbq.push_back(ex(2'b00, 2'b00, 0));
        idle(3);
        while (sq.size() > 0) begin
            @(negedge clk); drive(sq.pop_front()); #1;
            e = sbq.pop_front();
            checks++;
            if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st}) begin
                errors++;
                $display("FAIL x0 c%0d: a=%b b=%b st=%b want a=%b b=%b st=%b",
                         c, fwd_a_sel, fwd_b_sel, stall, e.a, e.b, e.st);
            end
            bump(e.st); c++;
        end
    endtask

    task automatic test_flush;
        exp_t e;
        int   c = 0;
        sq.push_back(mk(1, 1, 2, 9, 1, 1, 0));   sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(1, 9, 9, 16, 1, 0, 1));  sbq.push_back(ex(2'b00, 2'b00, 1));
        sq.push_back(mk(1, 9, 2, 17, 1, 0, 0));  sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(0, 0, 0, 0, 0, 0, 0));   sbq.push_back(ex(2'b01, 2'b00, 0));
        sq.push_back(mk(1, 1, 2, 20, 1, 0, 1));  sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(1, 20, 21, 22, 1, 0, 0)); sbq.push_back(ex(2'b00, 2'b00, 0));
        idle(3);
        while (sq.size() > 0) begin
            @(negedge clk); drive(sq.pop_front()); #1;
            e = sbq.pop_front();
            checks++;
            if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st}) begin
                errors++;
                $display("FAIL flush c%0d: a=%b b=%b st=%b want a=%b b=%b st=%b",
                         c, fwd_a_sel, fwd_b_sel, stall, e.a, e.b, e.st);
            end
            checks++;
            if (stall_count !== exp_cnt) begin
                errors++;
                $display("FAIL flush_cnt c%0d: got %0d want %0d", c, stall_count, exp_cnt);
            end
            bump(e.st); c++;
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   c = 0;
        sq.push_back(mk(1, 1, 2, 5, 1, 0, 0)); sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(1, 5, 2, 9, 1, 1, 0)); sbq.push_back(ex(2'b00, 2'b00, 0));
        sq.push_back(mk(1, 9, 4, 13, 1, 0, 0)); sbq.push_back(ex(2'b10, 2'b00, 1));
        while (sq.size() > 0) begin
            @(negedge clk); drive(sq.pop_front()); #1;
            e = sbq.pop_front();
            checks++;
            if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st}) begin
                errors++;
                $display("FAIL rst_mid_pre c%0d: a=%b b=%b st=%b want a=%b b=%b st=%b",
                         c, fwd_a_sel, fwd_b_sel, stall, e.a, e.b, e.st);
            end
            c++;
        end
        // Consumer still held in ID with the hazard live; reset lands mid-cycle.
        #1 rst_n = 1'b0;
        exp_cnt = '0; exp_sat = '0;
        #1;
        checks++;
        if ({fwd_a_sel, fwd_b_sel, stall} !== 5'b0 || stall_count !== 16'd0 || s_count !== 6'd0) begin
            errors++;
            $display("FAIL rst_mid_async: a=%b b=%b st=%b cnt=%0d scnt=%0d want all 0",
                     fwd_a_sel, fwd_b_sel, stall, stall_count, s_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({fwd_a_sel, fwd_b_sel, stall} !== 5'b0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_release: a=%b b=%b st=%b cnt=%0d want all 0",
                     fwd_a_sel, fwd_b_sel, stall, stall_count);
        end
        @(negedge clk); drive(mk(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
    endtask

    task automatic test_saturate;
        exp_t e;
        // A load that also consumes its own rd: stalls on every other cycle.
        for (int i = 0; i < 142; i++) begin
            sq.push_back(mk(1, 9, 9, 9, 1, 1, 0));
            if (i % 2 == 0)  sbq.push_back(ex(2'b00, 2'b00, 0));
            else if (i == 1) sbq.push_back(ex(2'b00, 2'b00, 1));
            else             sbq.push_back(ex(2'b01, 2'b01, 1));
        end
        for (int c = 0; sq.size() > 0; c++) begin
            @(negedge clk); drive(sq.pop_front()); #1;
            e = sbq.pop_front();
            checks++;
            if ({fwd_a_sel, fwd_b_sel, stall} !== {e.a, e.b, e.st}) begin
                errors++;
                $display("FAIL sat_pipe c%0d: a=%b b=%b st=%b want a=%b b=%b st=%b",
                         c, fwd_a_sel, fwd_b_sel, stall, e.a, e.b, e.st);
            end
            checks++;
            if (stall_count !== exp_cnt || s_count !== exp_sat) begin
                errors++;
                $display("FAIL sat_cnt c%0d: cnt=%0d scnt=%0d want %0d %0d",
                         c, stall_count, s_count, exp_cnt, exp_sat);
            end
            bump(e.st);
        end
        @(negedge clk); drive(mk(0, 0, 0, 0, 0, 0, 0)); #1;
        checks++;
        if (s_count !== 6'h3f || stall_count !== 16'd71) begin
            errors++;
            $display("FAIL sat_final: scnt=%0d cnt=%0d want 63 71", s_count, stall_count);
        end
    endtask

    initial begin
        test_reset;
        test_fwd_mem;
        test_fwd_wb;
        test_mem_priority;
        test_load_use;
        test_x0;
        test_flush;
        test_reset_mid;
        test_saturate;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
